// File: rtl/uart_rx_buf_pkg.sv
// Shared constants, helpers and receiver state encoding for uart_rx_buf.
// The PARITY state is only reached when UART_RX_PARITY_EN is defined.
package uart_rx_buf_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StStop   = 3'd3,
    StParity = 3'd4
  } rx_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return uart_div(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_buf_if.sv
// Byte stream handshake between the UART receive buffer and its consumer.
interface uart_rx_buf_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered show-ahead head entry.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [clog2(DEPTH):0]      count
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;
  assign rdata = head_q;

  always_comb begin
    do_pop  = pop & ~empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    do_push = push & (~full | do_pop);
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
    head_d  = head_q;
    if (wptr_d != rptr_d) begin
      if (do_push && (rptr_d == wptr_q)) head_d = wdata;
      else                               head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receive front-end: 8N1 deserialiser, byte FIFO and cts flow control.
// Defining UART_RX_PARITY_EN switches to 8E1 frames and adds the perr port.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned UART_FREQ  = 115200,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CTS_MARGIN = 2
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           rx,
  output logic           cts,
  output logic           ferr,
  output logic           ovf,
`ifdef UART_RX_PARITY_EN
  output logic           perr,
`endif
  uart_rx_buf_if.master  bus
);

  localparam int unsigned DIV  = uart_div(CLK_FREQ, UART_FREQ);
  localparam int unsigned HALF = half_div(CLK_FREQ, UART_FREQ);
  localparam int unsigned CntW = clog2(DIV);
  localparam int unsigned AW   = clog2(DEPTH);

  localparam logic [CntW-1:0] CntFull = CntW'(DIV - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            rx_meta_q, rxs_q;
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            brk_q;
  logic            ferr_q;
  logic            ovf_q;
  logic            cts_q;
  logic            push;
  logic            fifo_full, fifo_empty;
  logic [AW:0]     fifo_count;
`ifdef UART_RX_PARITY_EN
  logic            perr_q;
  logic            bad_par_q;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  // Push is decided on the stop-bit sample so the byte shows up on data the next cycle.
  always_comb begin
    push = 1'b0;
    if (state_q == StStop && !brk_q && cnt_q == '0 && rxs_q) push = 1'b1;
`ifdef UART_RX_PARITY_EN
    if (bad_par_q) push = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      brk_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      bad_par_q <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q <= 1'b0;
`endif
      if (cnt_q != '0) cnt_q <= cnt_q - CntOne;
      unique case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            cnt_q   <= CntHalf;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == '0) begin
            if (rxs_q) begin
              state_q <= StIdle;
            end else begin
              cnt_q     <= CntFull;
              bit_q     <= '0;
`ifdef UART_RX_PARITY_EN
              bad_par_q <= 1'b0;
`endif
              state_q   <= StData;
            end
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            shift_q <= {rxs_q, shift_q[7:1]};
            cnt_q   <= CntFull;
            bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_q <= StParity;
`else
            if (bit_q == 3'd7) state_q <= StStop;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_q == '0) begin
            bad_par_q <= ^{shift_q, rxs_q};
            perr_q    <= ^{shift_q, rxs_q};
            cnt_q     <= CntFull;
            state_q   <= StStop;
          end
        end
`endif
        StStop: begin
          // A low stop bit may be a break: hold here until the line idles again.
          if (brk_q) begin
            if (rxs_q) begin
              brk_q   <= 1'b0;
              state_q <= StIdle;
            end
          end else if (cnt_q == '0) begin
            if (rxs_q) begin
              state_q <= StIdle;
            end else begin
              ferr_q <= 1'b1;
              brk_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push    (push),
    .wdata   (shift_q),
    .pop     (bus.ready),
    .rdata   (bus.data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ovf_q <= 1'b0;
      cts_q <= 1'b1;
    end else begin
      if (push && fifo_full && !bus.ready) ovf_q <= 1'b1;
      cts_q <= (DEPTH - 32'(fifo_count)) > CTS_MARGIN;
    end
  end

  assign bus.valid = ~fifo_empty;
  assign cts       = cts_q;
  assign ferr      = ferr_q;
  assign ovf       = ovf_q;
`ifdef UART_RX_PARITY_EN
  assign perr      = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf with a byte scoreboard on the consumer side.
// Also covers bad parity when built with UART_RX_PARITY_EN.
module tb_uart_rx_buf;
  import uart_rx_buf_pkg::*;

  localparam int unsigned DIV = 12000000 / 115200;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic rx = 1'b1;
  logic cts, ferr, ovf;
`ifdef UART_RX_PARITY_EN
  logic perr;
  bit   flip_par = 1'b0;
`endif

  uart_rx_buf_if bus ();

  uart_rx_buf #(
    .CLK_FREQ   (12000000),
    .UART_FREQ  (115200),
    .DEPTH      (8),
    .CTS_MARGIN (2)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .rx      (rx),
    .cts     (cts),
    .ferr    (ferr),
    .ovf     (ovf),
`ifdef UART_RX_PARITY_EN
    .perr    (perr),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int unsigned chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
  int unsigned rx_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int unsigned last_pop_cyc = 0, start_cyc = 0;
  int unsigned sim_n = 0;
  bit          sim_found = 1'b0;
  logic [7:0]  exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Consumer-side monitor: every accepted byte is checked against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (n_reset) begin
      if (ferr) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (perr) perr_cnt++;
`endif
      if (bus.valid && bus.ready) begin
        last_pop_cyc = cyc;
        rx_cnt++;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", 32'(bus.data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #(90000 * 10);
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bit_wait();
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    start_cyc = cyc;
    rx = 1'b0;
    bit_wait();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_wait();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ flip_par;
    bit_wait();
`endif
    rx = stop_ok;
    bit_wait();
    rx = 1'b1;
    bit_wait();
  endtask

  task automatic wait_rx(input int unsigned target, input string tag);
    int unsigned n;
    n = 0;
    while (rx_cnt < target && n < 4 * DIV) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, rx_cnt, target);
  endtask

  initial begin
    bus.ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_data",  32'(bus.data),  32'd0);
    check("rst_cts",   32'(cts),       32'd1);
    check("rst_ferr",  32'(ferr),      32'd0);
    check("rst_ovf",   32'(ovf),       32'd0);
    check("rst_state", 32'(dut.state_q), 32'(StIdle));
    n_reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Normal byte and its latency from the start edge.
    bus.ready = 1'b1;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1);
    wait_rx(1, "rx_55");
    check("lat_lo", 32'((last_pop_cyc - start_cyc) >= (DIV * 17) / 2), 32'd1);
    check("lat_hi", 32'((last_pop_cyc - start_cyc) <= DIV * 10), 32'd1);
    check("ferr_none", ferr_cnt, 32'd0);

    // Short glitch is rejected as a false start.
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    check("glitch_rx",    rx_cnt, 32'd1);
    check("glitch_ferr",  ferr_cnt, 32'd0);
    check("glitch_state", 32'(dut.state_q), 32'(StIdle));

    // Framing error, then a good frame.
    send(8'hA3, 1'b0);
    check("ferr_pulse", ferr_cnt, 32'd1);
    check("ferr_empty", 32'(bus.valid), 32'd0);
    check("ferr_rx",    rx_cnt, 32'd1);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    wait_rx(2, "rx_3c");
    check("ferr_once", ferr_cnt, 32'd1);

    // Flow control and overflow.
    bus.ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      send(8'(8'h10 + i), 1'b1);
    end
    check("cts_5", 32'(cts), 32'd1);
    exp_q.push_back(8'h15);
    send(8'h15, 1'b1);
    check("cts_6", 32'(cts), 32'd0);
    exp_q.push_back(8'h16);
    send(8'h16, 1'b1);
    exp_q.push_back(8'h17);
    send(8'h17, 1'b1);
    check("ovf_8",  32'(ovf), 32'd0);
    check("head_8", 32'(bus.data), 32'h10);
    send(8'h18, 1'b1);
    check("ovf_9",  32'(ovf), 32'd1);
    bus.ready = 1'b1;
    wait_rx(10, "drain_8");
    repeat (4) @(posedge clk);
    #1;
    check("cts_back", 32'(cts), 32'd1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // Reset during bit 4 of 0xFF, with a byte parked in the FIFO.
    bus.ready = 1'b0;
    send(8'h11, 1'b1);
    check("park_valid", 32'(bus.valid), 32'd1);
    check("park_data",  32'(bus.data),  32'h11);
    rx = 1'b0;
    bit_wait();
    rx = 1'b1;
    repeat (4) bit_wait();
    repeat (DIV / 2) @(posedge clk);
    #1;
    n_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mrst_valid", 32'(bus.valid), 32'd0);
    check("mrst_data",  32'(bus.data),  32'd0);
    check("mrst_cts",   32'(cts),       32'd1);
    check("mrst_ovf",   32'(ovf),       32'd0);
    check("mrst_state", 32'(dut.state_q), 32'(StIdle));
    n_reset = 1'b1;
    repeat (5 * DIV) @(posedge clk);
    #1;
    bus.ready = 1'b1;
    exp_q.push_back(8'h00);
    send(8'h00, 1'b1);
    wait_rx(11, "rx_00");

    // Full FIFO with a pop on the exact cycle of a new push.
    bus.ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send(8'(8'h20 + i), 1'b1);
    end
    check("full_cts", 32'(cts), 32'd0);
    exp_q.push_back(8'h28);
    fork
      send(8'h28, 1'b1);
      begin
        sim_n = 0;
        while (!(dut.state_q == StStop && dut.cnt_q == '0 && !dut.brk_q) && sim_n < 20 * DIV)
        begin
          @(posedge clk);
          #1;
          sim_n++;
        end
        sim_found = (sim_n < 20 * DIV);
        bus.ready = 1'b1;
        @(posedge clk);
        #1;
        bus.ready = 1'b0;
      end
    join
    check("simul_found", 32'(sim_found), 32'd1);
    check("simul_ovf",   32'(ovf), 32'd0);
    check("simul_head",  32'(bus.data), 32'h21);
    bus.ready = 1'b1;
    wait_rx(20, "simul_drain");
    check("simul_sb", 32'(exp_q.size()), 32'd0);
    check("end_ovf",  32'(ovf), 32'd0);

`ifdef UART_RX_PARITY_EN
    flip_par = 1'b1;
    send(8'h5A, 1'b1);
    flip_par = 1'b0;
    check("perr_pulse", perr_cnt, 32'd1);
    check("perr_nopush", rx_cnt, 32'd20);
    check("perr_empty", 32'(bus.valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf.md
Name: uart_rx_buf

Overview:
- UART receive front-end that sits directly upstream of the dbgu32 debug unit and feeds it command/data bytes.
- Deserialises 8N1 frames from the host `rx` pin and buffers bytes in a small FIFO.
- Presents bytes on a valid/ready interface.
- Drives `cts` so the host pauses before the FIFO overflows.

Parameters:
- CLK_FREQ, 12000000, system clock in Hz.
- UART_FREQ, 115200, baud rate; DIV = CLK_FREQ/UART_FREQ (integer division, must be ≥ 8).
- DEPTH, 8, FIFO entries; power of two, 2..64.
- CTS_MARGIN, 2, free-entry threshold at or below which cts is deasserted.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- rx  in  1  serial input from host; asynchronous, idles high.
- cts  out  1  1 = host may send; 0 = host must pause after the current frame.
- data  out  8  head-of-FIFO byte.
- valid  out  1  data holds an unread byte.
- ready  in  1  consumer accepts data this cycle when valid & ready.
- ferr  out  1  one-cycle pulse on a framing error.
- ovf  out  1  sticky overflow flag, cleared only by reset.

Behaviour:
- Reset values (asynchronous on n_reset low):
  - FIFO empty, pointers 0.
  - valid=0, data=0, cts=1, ferr=0, ovf=0.
  - Receiver state IDLE.
  - rx synchroniser preset to 1.
- rx input: passes through a 2-FF synchroniser; all logic uses the synchronised bit rxs.
- Receiver FSM, states IDLE, START, DATA, STOP; cnt is a baud counter of width clog2(DIV).
  - IDLE: on rxs==0, load cnt=DIV/2-1 and go to START.
  - START: when cnt reaches 0, sample rxs.
    - rxs==1: false start, go to IDLE, no ferr.
    - rxs==0: load cnt=DIV-1, bit index=0, go to DATA.
  - DATA: each time cnt reaches 0, shift rxs into bit 7 of the shift register (LSB first) and reload cnt=DIV-1. After the 8th sample, go to STOP.
  - STOP: when cnt reaches 0, sample rxs.
    - rxs==1: push the byte, go to IDLE.
    - rxs==0: drop the byte, pulse ferr for 1 cycle, go to IDLE only after rxs returns high (break handling).
- Latency: the byte is visible on data with valid=1 one clk after the stop-bit sample (registered push).
- FIFO:
  - Pointers are clog2(DEPTH)+1 bits; full/empty are distinguished by the MSB.
  - data is the registered head entry (show-ahead); valid = !empty.
  - Pop occurs on valid & ready. data updates to the next entry in the following cycle, with no bubble when more entries remain.
- Simultaneous push and pop:
  - Allowed in any state, including full.
  - Pop-while-full then push succeeds; count is unchanged.
- Push when full with no pop in the same cycle: byte discarded, ovf set to 1, FIFO contents untouched.
- Pop when empty: ignored.
- cts:
  - Registered; cts = (DEPTH - count) > CTS_MARGIN, evaluated every cycle.
  - Reasserts as soon as the condition holds again.
- Mid-frame reset: the FSM returns to IDLE and the partial byte is lost. If rx is low when reset is released, the receiver starts a frame on that low level; this is accepted.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- With the macro defined:
  - Frames are 8E1; a PARITY state sits between DATA and STOP.
  - Even parity is checked against the 9th bit.
  - On mismatch, the byte is dropped and an extra port `perr` (out, 1) pulses for 1 cycle. Stop bit handling is unchanged.
- Without the macro: 8N1 only; the `perr` port does not exist.

Decomposition:
- Shared package: UART_DIV and half-divider constant functions; FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4); clog2 helper.
- Sub-module: `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated once. The UART FSM stays in uart_rx_buf.

Test Plan:
- Normal byte (defaults, DIV=104): send 0x55, ready=1 → valid pulses once with data=0x55, 8.5–10 bit times after the start edge; ferr=0.
- Glitch: 20-cycle low pulse on rx → no byte, no ferr, FSM back in IDLE.
- Framing error: send 0xA3 with stop bit forced low for 1 bit time → ferr pulses once, FIFO stays empty, next valid frame 0x3C is received correctly.
- Flow control/overflow (ready=0, DEPTH=8, CTS_MARGIN=2):
  - Send 6 bytes → cts falls after the 6th push.
  - Send 3 more → 2 stored, 9th sets ovf=1.
  - Raise ready → 8 bytes popped in order, cts returns to 1.
- Simultaneous push/pop: FIFO full, ready asserted on the cycle of a new push → no loss, ovf stays 0, order preserved.
- Reset mid-frame: assert n_reset during bit 4 of 0xFF → outputs return to reset values; subsequent byte 0x00 is received correctly; with UART_RX_PARITY_EN, a bad-parity byte gives a perr pulse and no push.
